// File: rtl/ecc_ctrl_pkg.sv
// Shared types and constants for the ECC operation controller.
package ecc_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENC   = 3'd1,
        ST_SYN   = 3'd2,
        ST_CHK   = 3'd3,
        ST_WRITE = 3'd4
    } ctrl_state_t;

    // Opcodes carried by the CTRL register
    localparam logic [1:0] OP_ENC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_FULL = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Codeword modes
    localparam logic [1:0] MOD_8  = 2'd0;
    localparam logic [1:0] MOD_16 = 2'd1;
    localparam logic [1:0] MOD_32 = 2'd2;

    // Output-register source select
    localparam logic [1:0] RES_ENC = 2'b00;
    localparam logic [1:0] RES_DEC = 2'b01;

    // Only the reserved opcode is rejected; mode legality is checked separately
    function automatic logic op_legal(input logic [1:0] op);
        return (op != OP_RSVD);
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Shared 3-bit stage counter: cleared on every stage entry, flags the final
// cycle of a stage whose length is supplied per stage through 'lat'.
module stage_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] lat,
    output logic [2:0] cnt,
    output logic       last
);

    logic [2:0] cnt_reg;

    // Count cycles spent in the current stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= 3'd0;
        end else if (clr) begin
            cnt_reg <= 3'd0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 3'd1;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == (lat - 3'd1));

endmodule

// File: rtl/ecc_op_ctrl.sv
// ECC operation controller: latches a start command and mode, then walks the
// encoder / syndrome / decoder-check stages with one-cycle launch strobes,
// writes the selected result and reports completion or command rejection.
module ecc_op_ctrl
    import ecc_ctrl_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int ENC_LAT   = 1,
    parameter int SYN_LAT   = 1,
    parameter int CHK_LAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           ctrl,
    input  logic [AMBA_WORD-1:0] work_mod,
    output logic [1:0]           mod_q,
    output logic                 busy,
    output logic                 enc_en,
    output logic                 syn_en,
    output logic                 chk_en,
    output logic                 sel_noise,
    output logic [1:0]           result_sel,
    output logic                 result_we,
    output logic                 operation_done,
    output logic                 cmd_err
);

    localparam logic [2:0] ENC_LAT_C = 3'(ENC_LAT);
    localparam logic [2:0] SYN_LAT_C = 3'(SYN_LAT);
    localparam logic [2:0] CHK_LAT_C = 3'(CHK_LAT);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;
    logic [1:0]  op_reg;
    logic [1:0]  mod_reg;
    logic        done_reg;
    logic        err_reg;

    logic        cmd_ok;
    logic        accept;
    logic        reject;
    logic        stage_clr;
    logic        stage_act;
    logic [2:0]  stage_lat;
    logic [2:0]  stage_cnt;
    logic        stage_last;

    // Full-width mode compare so any upper bit set makes the mode illegal
    assign cmd_ok = op_legal(ctrl) && (work_mod <= AMBA_WORD'(MOD_32));
    assign accept = (state_reg == ST_IDLE) && start && cmd_ok;
    assign reject = (state_reg == ST_IDLE) && start && !cmd_ok;

    // Length of the stage the FSM is currently in
    always_comb begin
        stage_lat = 3'd1;
        case (state_reg)
            ST_ENC:  stage_lat = ENC_LAT_C;
            ST_SYN:  stage_lat = SYN_LAT_C;
            ST_CHK:  stage_lat = CHK_LAT_C;
            default: stage_lat = 3'd1;
        endcase
    end

    // Any state change restarts the counter so each stage begins at zero
    assign stage_clr = (state_next != state_reg);
    assign stage_act = (state_reg == ST_ENC) || (state_reg == ST_SYN) ||
                       (state_reg == ST_CHK);

    stage_timer u_stage_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (stage_clr),
        .en   (stage_act),
        .lat  (stage_lat),
        .cnt  (stage_cnt),
        .last (stage_last)
    );

    // Next-state sequencing; later stages follow the latched opcode
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (ctrl == OP_DEC) ? ST_SYN : ST_ENC;
                end
            end
            ST_ENC: begin
                if (stage_last) begin
                    state_next = (op_reg == OP_FULL) ? ST_SYN : ST_WRITE;
                end
            end
            ST_SYN: begin
                if (stage_last) begin
                    state_next = ST_CHK;
                end
            end
            ST_CHK: begin
                if (stage_last) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, latched command and status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            op_reg    <= OP_ENC;
            mod_reg   <= MOD_8;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= ctrl;
                mod_reg  <= work_mod[1:0];
                done_reg <= 1'b0;
                err_reg  <= 1'b0;
            end else if (reject) begin
                done_reg <= 1'b1;
                err_reg  <= 1'b1;
            end else if (state_reg == ST_WRITE) begin
                done_reg <= 1'b1;
            end
        end
    end

    // Moore output decode from state and stage counter
    assign mod_q          = mod_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign enc_en         = (state_reg == ST_ENC) && (stage_cnt == 3'd0);
    assign syn_en         = (state_reg == ST_SYN) && (stage_cnt == 3'd0);
    assign chk_en         = (state_reg == ST_CHK) && (stage_cnt == 3'd0);
    assign sel_noise      = (op_reg == OP_FULL) &&
                            ((state_reg == ST_SYN) || (state_reg == ST_CHK));
    assign result_we      = (state_reg == ST_WRITE);
    assign result_sel     = (state_reg != ST_WRITE) ? RES_ENC :
                            (op_reg == OP_ENC)      ? RES_ENC : RES_DEC;
    assign operation_done = done_reg;
    assign cmd_err        = err_reg;

endmodule

// File: tb/tb_ecc_op_ctrl.sv
// Directed bench for ecc_op_ctrl: expected per-cycle output records are
// queued when a command is issued and compared as the DUT advances.
module tb_ecc_op_ctrl;
    import ecc_ctrl_pkg::*;

    localparam int E_LAT = 2;
    localparam int S_LAT = 1;
    localparam int C_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  ctrl = 2'b00;
    logic [31:0] work_mod = 32'd0;
    logic [1:0]  mod_q;
    logic        busy, enc_en, syn_en, chk_en, sel_noise, result_we;
    logic        operation_done, cmd_err;
    logic [1:0]  result_sel;

    typedef struct packed {
        logic       busy;
        logic       enc;
        logic       syn;
        logic       chk;
        logic       noise;
        logic       we;
        logic [1:0] rsel;
        logic       done;
        logic       err;
        logic [1:0] mod;
    } obs_t;

    obs_t  exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    string cur_tag = "reset";
    logic [1:0] cur_mod = 2'd0;

    ecc_op_ctrl #(
        .AMBA_WORD (32),
        .ENC_LAT   (E_LAT),
        .SYN_LAT   (S_LAT),
        .CHK_LAT   (C_LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ctrl           (ctrl),
        .work_mod       (work_mod),
        .mod_q          (mod_q),
        .busy           (busy),
        .enc_en         (enc_en),
        .syn_en         (syn_en),
        .chk_en         (chk_en),
        .sel_noise      (sel_noise),
        .result_sel     (result_sel),
        .result_we      (result_we),
        .operation_done (operation_done),
        .cmd_err        (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t sample();
        obs_t o;
        o.busy  = busy;
        o.enc   = enc_en;
        o.syn   = syn_en;
        o.chk   = chk_en;
        o.noise = sel_noise;
        o.we    = result_we;
        o.rsel  = result_sel;
        o.done  = operation_done;
        o.err   = cmd_err;
        o.mod   = mod_q;
        return o;
    endfunction

    function automatic obs_t mk(logic b, logic en, logic sy, logic ch, logic nz,
                                logic we, logic [1:0] rs, logic dn, logic er,
                                logic [1:0] md);
        obs_t r;
        r.busy = b; r.enc = en; r.syn = sy; r.chk = ch; r.noise = nz;
        r.we = we; r.rsel = rs; r.done = dn; r.err = er; r.mod = md;
        return r;
    endfunction

    task automatic check(input string tag, input obs_t e);
        obs_t o;
        o = sample();
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed busy/enc/syn/chk/nz/we/rsel/done/err/mod=%b expected %b",
                   tag, o, e);
        end
        $display("vec %0d %s obs=%b", vectors, tag, o);
    endtask

    // Queue the expected trace of a legal command, from the first cycle after
    // the accepting edge through the first idle cycle showing operation_done.
    task automatic push_op(input logic [1:0] op, input logic [1:0] md);
        int nst;
        int lats[3];
        int kinds[3];
        if (op == OP_ENC) begin
            nst = 1; kinds[0] = 0; lats[0] = E_LAT;
        end else if (op == OP_DEC) begin
            nst = 2; kinds[0] = 1; lats[0] = S_LAT; kinds[1] = 2; lats[1] = C_LAT;
        end else begin
            nst = 3; kinds[0] = 0; lats[0] = E_LAT; kinds[1] = 1; lats[1] = S_LAT;
            kinds[2] = 2; lats[2] = C_LAT;
        end
        for (int s = 0; s < nst; s++) begin
            for (int k = 0; k < lats[s]; k++) begin
                exp_q.push_back(mk(1'b1, (kinds[s] == 0) && (k == 0),
                                   (kinds[s] == 1) && (k == 0),
                                   (kinds[s] == 2) && (k == 0),
                                   (op == OP_FULL) && (kinds[s] != 0),
                                   1'b0, 2'b00, 1'b0, 1'b0, md));
            end
        end
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                           (op == OP_ENC) ? 2'b00 : 2'b01, 1'b0, 1'b0, md));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, md));
        cur_mod = md;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc++;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s c%0d: observed empty scoreboard, expected queued record", cur_tag, cyc);
        end else begin
            check($sformatf("%s c%0d", cur_tag, cyc), exp_q.pop_front());
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            step();
            guard++;
        end
    endtask

    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] md);
        cur_tag  = tag;
        cyc      = 0;
        ctrl     = op;
        work_mod = md;
        start    = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset", mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Encode, 8-bit
        issue("enc8", OP_ENC, 32'd0);
        push_op(OP_ENC, MOD_8);
        drain();

        // Full channel, 32-bit
        issue("full32", OP_FULL, 32'd2);
        push_op(OP_FULL, MOD_32);
        drain();

        // Reserved opcode rejected
        issue("bad_op", OP_RSVD, 32'd1);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, cur_mod));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, cur_mod));
        drain();

        // Illegal mode rejected
        issue("bad_mod", OP_DEC, 32'd5);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, cur_mod));
        drain();

        // Upper mode bits set is also illegal
        issue("bad_hi", OP_ENC, 32'h0001_0000);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 1, cur_mod));
        drain();

        // Decode, 16-bit, with a second start during SYN that must be ignored
        issue("dec16", OP_DEC, 32'd1);
        push_op(OP_DEC, MOD_16);
        step();
        ctrl     = OP_ENC;
        work_mod = 32'd0;
        start    = 1'b1;
        drain();

        // Reset asserted during CHK of a full-channel operation
        issue("rst_mid", OP_FULL, 32'd1);
        push_op(OP_FULL, MOD_16);
        for (int i = 0; i < E_LAT + S_LAT + 1; i++) begin
            step();
        end
        exp_q.delete();
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid async", mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0));
        @(posedge clk);
        #1;
        check("rst_mid held", mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 2'd0));
        @(negedge clk);
        rst = 1'b1;

        // Decode after reset completes normally
        issue("dec_after_rst", OP_DEC, 32'd2);
        push_op(OP_DEC, MOD_32);
        drain();

        // Start during WRITE ignored, start in the following idle cycle taken
        issue("enc_wr", OP_ENC, 32'd1);
        push_op(OP_ENC, MOD_16);
        for (int i = 0; i < E_LAT + 1; i++) begin
            step();
        end
        ctrl     = OP_FULL;
        work_mod = 32'd0;
        start    = 1'b1;
        step();
        issue("dec_b2b", OP_DEC, 32'd0);
        push_op(OP_DEC, MOD_8);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
